avr_spi_framer: RTL and testbench
=================================

// Module: avr_spi_framer
// PURPOSE
//  Parametrised successor to the single-byte SPI capture path behind the AVR link.
//  Sits between the SPI slave byte engine and the user logic.
//  Assembles multi-byte SPI frames from the AVR into {channel, sample} words and
//  buffers them in a FWFT FIFO with valid/ready output.
//  Counts short (aborted) frames, bad channels and FIFO overflows.
// PARAMETERS
//  SAMPLE_BITS  10  sample width; frame bits [SAMPLE_BITS-1:0], little-endian bytes
//  CH_BITS      4   channel field width; top CH_BITS of last byte of frame
//  NUM_CH       10  valid channel ids 0..NUM_CH-1; others dropped
//  FRAME_BYTES  2   bytes per frame; elaboration error if SAMPLE_BITS+CH_BITS > 8*FRAME_BYTES
//  DEPTH        8   FIFO entries, power of 2, >=2
// PORTS
//  clk           in   1            system clock
//  rst           in   1            synchronous, active-high reset
//  ready         in   1            AVR ready (cclk detector); low acts as reset
//  spi_ss        in   1            slave select, active low
//  spi_done      in   1            1-cycle strobe: spi_dout holds a received byte
//  spi_dout      in   8            received byte
//  m_valid       out  1            FIFO head valid
//  m_ready       in   1            consumer accepts head when m_valid&&m_ready
//  m_sample      out  SAMPLE_BITS  head sample
//  m_channel     out  CH_BITS      head channel
//  fifo_level    out  $clog2(DEPTH)+1  entries held
//  abort_cnt     out  8            frames cut short by spi_ss high, saturating
//  chan_err_cnt  out  8            frames with channel >= NUM_CH, saturating
//  ovf_cnt       out  8            frames dropped because FIFO full, saturating
// BEHAVIOUR
//  - srst = rst | !ready. srst: FSM IDLE, byte_idx=0, FIFO empty, m_valid=0,
//    m_sample=0, m_channel=0, fifo_level=0, all counters 0. Mid-frame srst discards partial frame.
//  - FSM IDLE: spi_ss low -> COLLECT, byte_idx=0.
//  - FSM COLLECT: spi_done stores spi_dout at asm[8*byte_idx+:8], byte_idx++.
//    Byte FRAME_BYTES-1 completes the frame -> DISCARD.
//  - FSM DISCARD: further bytes ignored until spi_ss high -> IDLE.
//  - spi_ss high in COLLECT with byte_idx>0 (no completion this cycle): abort_cnt++, -> IDLE.
//    With byte_idx==0: -> IDLE, no count.
//  - spi_done and spi_ss high in the same cycle: the byte is processed first
//    (it may complete the frame), then -> IDLE.
//  - Frame complete at cycle T: push {channel, sample} at T+1 (registered).
//    Empty FIFO: m_valid=1 and data visible at T+2; holds until accepted.
//  - Push rules:
//    channel >= NUM_CH: no push, chan_err_cnt++.
//    Full and no pop this cycle: no push, ovf_cnt++.
//    Full with pop in the same cycle: push accepted, level unchanged.
//  - Simultaneous push+pop at any level: level unchanged, order preserved.
//  - Pointers wrap modulo DEPTH. Level counts 0..DEPTH. Counters stick at 8'hFF.
//  - Outputs change only when popped or written into an empty FIFO; stable while m_valid&&!m_ready.
// STRUCTURE
//  - avr_pkg: FSM state enum {IDLE, COLLECT, DISCARD}; counter width 8; helper
//    function for frame-bit slicing.
//  - Sub-module avr_sync_fifo (WIDTH, DEPTH): FWFT, synchronous reset, level output.
//  - Top level holds the FSM, assembly register, push logic and counters.
// TESTING
//  - Frame 8'h5A,8'h32 -> m_channel=3, m_sample=10'h25A; m_valid 2 cycles after last spi_done.
//  - One byte 8'h11 then spi_ss high -> abort_cnt=1, no push; next full frame captured normally.
//  - 3 bytes in one ss window (FRAME_BYTES=2) -> one push, third byte ignored, no error.
//  - Channel 4'hC (NUM_CH=10) -> chan_err_cnt=1, fifo_level unchanged.
//  - m_ready=0, 10 frames, DEPTH=8 -> level=8, ovf_cnt=2.
//    Then pop+push same cycle -> level stays 8, order intact.
//  - ready dropped mid-frame -> all outputs 0.
//    After ready high, SAMPLE_BITS=12 FRAME_BYTES=2 build: 8'hFF,8'h4F -> ch 4, sample 12'hFFF.

Source files
------------

// File: rtl/avr_pkg.sv
// Shared types and helpers for the AVR SPI framer.
//   state_e   : frame assembly FSM states
//   CNT_W     : width of the saturating error counters
//   chan_lsb  : bit position of the channel field inside an assembled frame
//   sat_inc   : saturating counter increment
package avr_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDiscard
  } state_e;

  // The channel occupies the top ch_bits of the last (most significant) byte.
  function automatic int unsigned chan_lsb(int unsigned frame_bytes, int unsigned ch_bits);
    return 8 * frame_bytes - ch_bits;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] cnt, logic en);
    return (en && (cnt != {CNT_W{1'b1}})) ? cnt + CNT_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/avr_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  : write request; honoured when not full or when a read happens too
//   rd_en           : pops the head when rd_valid
//   rd_data         : head entry, zero while empty
//   rd_valid, full  : status flags
//   level           : number of entries held, 0..DEPTH
module avr_sync_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
    $error("avr_sync_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_wr, do_rd;

  always_comb begin
    rd_valid = (level_q != '0);
    full     = (level_q == LvlW'(DEPTH));
    do_rd    = rd_en && rd_valid;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (do_wr && !do_rd) begin
      level_d = level_q + LvlW'(1);
    end else if (do_rd && !do_wr) begin
      level_d = level_q - LvlW'(1);
    end
    rd_data = rd_valid ? mem_q[rd_ptr_q] : '0;
    level   = level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: reads are gated by rd_valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/avr_spi_framer.sv
// Assembles multi-byte SPI frames from the AVR into {channel, sample} words and
// queues them in a FWFT FIFO with a valid/ready output.
//   clk, rst            : clock, synchronous active-high reset
//   ready               : AVR link ready; low holds the block in reset
//   spi_ss              : slave select, active low
//   spi_done, spi_dout  : one-cycle strobe with the received byte
//   m_valid/m_ready     : output handshake; m_sample/m_channel hold the head entry
//   fifo_level          : entries held
//   abort_cnt           : frames cut short by slave select, saturating
//   chan_err_cnt        : frames with an out-of-range channel, saturating
//   ovf_cnt             : frames dropped on a full FIFO, saturating
module avr_spi_framer
  import avr_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS = 10,
  parameter int unsigned CH_BITS     = 4,
  parameter int unsigned NUM_CH      = 10,
  parameter int unsigned FRAME_BYTES = 2,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ready,
  input  logic                     spi_ss,
  input  logic                     spi_done,
  input  logic [7:0]               spi_dout,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [SAMPLE_BITS-1:0]   m_sample,
  output logic [CH_BITS-1:0]       m_channel,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         abort_cnt,
  output logic [CNT_W-1:0]         chan_err_cnt,
  output logic [CNT_W-1:0]         ovf_cnt
);

  localparam int unsigned FrameW = 8 * FRAME_BYTES;
  localparam int unsigned IdxW   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int unsigned ChLsb  = chan_lsb(FRAME_BYTES, CH_BITS);
  localparam int unsigned WordW  = CH_BITS + SAMPLE_BITS;

  if (SAMPLE_BITS + CH_BITS > 8 * FRAME_BYTES) begin : gen_bad_frame
    $error("avr_spi_framer: SAMPLE_BITS + CH_BITS exceeds the frame width");
  end
  if (CH_BITS > 8) begin : gen_bad_ch
    $error("avr_spi_framer: channel field must fit in the last byte");
  end

  logic              srst;
  state_e            state_q, state_d;
  logic [IdxW-1:0]   byte_idx_q, byte_idx_d;
  logic [FrameW-1:0] asm_q, asm_d;
  logic              pend_q, pend_d;
  logic [WordW-1:0]  pend_word_q, pend_word_d;
  logic [CNT_W-1:0]  abort_q, abort_d;
  logic [CNT_W-1:0]  chan_err_q, chan_err_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;

  logic              byte_take, last_byte, frame_done, abort_now;
  logic              pop, push, chan_bad, fifo_full;
  logic [CH_BITS-1:0] pend_ch;
  logic [WordW-1:0]  head_word;

  assign srst = rst || !ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. A byte arriving with spi_ss high is handled before leaving.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (!spi_ss) state_d = StCollect;
      StCollect: begin
        if (spi_ss) begin
          state_d = StIdle;
        end else if (frame_done) begin
          state_d = StDiscard;
        end
      end
      StDiscard: if (spi_ss) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs: byte capture, frame completion and abort detection.
  always_comb begin
    byte_take  = (state_q == StCollect) && spi_done;
    last_byte  = (byte_idx_q == IdxW'(FRAME_BYTES - 1));
    frame_done = byte_take && last_byte;
    // Partial frame still open after this cycle's byte, and slave select released.
    abort_now  = (state_q == StCollect) && spi_ss && !frame_done &&
                 ((byte_idx_q != '0) || byte_take);

    asm_d = asm_q;
    if (byte_take) begin
      asm_d[{byte_idx_q, 3'b000} +: 8] = spi_dout;
    end

    byte_idx_d = byte_idx_q;
    if (state_q != StCollect) begin
      byte_idx_d = '0;
    end else if (byte_take && !last_byte) begin
      byte_idx_d = byte_idx_q + IdxW'(1);
    end

    pend_d      = frame_done;
    pend_word_d = frame_done ? {asm_d[ChLsb +: CH_BITS], asm_d[SAMPLE_BITS-1:0]} : pend_word_q;
  end

  // Push decision one cycle after completion, against the FIFO state of that cycle.
  always_comb begin
    pend_ch  = pend_word_q[WordW-1 -: CH_BITS];
    pop      = m_valid && m_ready;
    chan_bad = (32'(pend_ch) >= NUM_CH);
    push     = pend_q && !chan_bad && (!fifo_full || pop);

    abort_d    = sat_inc(abort_q, abort_now);
    chan_err_d = sat_inc(chan_err_q, pend_q && chan_bad);
    ovf_d      = sat_inc(ovf_q, pend_q && !chan_bad && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      byte_idx_q  <= '0;
      asm_q       <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      abort_q     <= '0;
      chan_err_q  <= '0;
      ovf_q       <= '0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      abort_q     <= abort_d;
      chan_err_q  <= chan_err_d;
      ovf_q       <= ovf_d;
    end
  end

  avr_sync_fifo #(
    .WIDTH (WordW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (srst),
    .wr_en    (push),
    .wr_data  (pend_word_q),
    .rd_en    (m_ready),
    .rd_data  (head_word),
    .rd_valid (m_valid),
    .full     (fifo_full),
    .level    (fifo_level)
  );

  always_comb begin
    m_channel    = head_word[WordW-1 -: CH_BITS];
    m_sample     = head_word[SAMPLE_BITS-1:0];
    abort_cnt    = abort_q;
    chan_err_cnt = chan_err_q;
    ovf_cnt      = ovf_q;
  end

endmodule

// File: tb/tb_avr_spi_framer.sv
module tb_avr_spi_framer;

  localparam int SB    = 10;
  localparam int CB    = 4;
  localparam int NCH   = 10;
  localparam int FB    = 2;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, ready, spi_ss, spi_done, m_ready;
  logic [7:0] spi_dout;

  logic          m_valid;
  logic [SB-1:0] m_sample;
  logic [CB-1:0] m_channel;
  logic [3:0]    fifo_level;
  logic [7:0]    abort_cnt, chan_err_cnt, ovf_cnt;

  logic          w_valid;
  logic [11:0]   w_sample;
  logic [3:0]    w_channel;
  logic [3:0]    w_level;
  logic [7:0]    w_abort, w_cerr, w_ovf;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  avr_spi_framer #(
    .SAMPLE_BITS (SB),
    .CH_BITS     (CB),
    .NUM_CH      (NCH),
    .FRAME_BYTES (FB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .spi_ss       (spi_ss),
    .spi_done     (spi_done),
    .spi_dout     (spi_dout),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_sample     (m_sample),
    .m_channel    (m_channel),
    .fifo_level   (fifo_level),
    .abort_cnt    (abort_cnt),
    .chan_err_cnt (chan_err_cnt),
    .ovf_cnt      (ovf_cnt)
  );

  // Wide-sample build sharing the same stimulus.
  avr_spi_framer #(
    .SAMPLE_BITS (12),
    .CH_BITS     (4),
    .NUM_CH      (10),
    .FRAME_BYTES (2),
    .DEPTH       (8)
  ) dut12 (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .spi_ss       (spi_ss),
    .spi_done     (spi_done),
    .spi_dout     (spi_dout),
    .m_valid      (w_valid),
    .m_ready      (m_ready),
    .m_sample     (w_sample),
    .m_channel    (w_channel),
    .fifo_level   (w_level),
    .abort_cnt    (w_abort),
    .chan_err_cnt (w_cerr),
    .ovf_cnt      (w_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         q_smp[$];
  int         q_ch[$];
  bit         pend;
  int         pend_smp, pend_ch;
  bit         in_win;
  int         cnt;
  logic [7:0] fb[FB];
  int         m_abort, m_cerr, m_ovf;

  task automatic model_step();
    int      sz;
    bit      pop, push, done_now;
    longint  w;
    if (rst || !ready) begin
      q_smp.delete(); q_ch.delete();
      pend = 0; in_win = 0; cnt = 0;
      m_abort = 0; m_cerr = 0; m_ovf = 0;
      return;
    end
    sz       = q_smp.size();
    pop      = (sz > 0) && m_ready;
    push     = 0;
    done_now = 0;
    if (pend) begin
      if (pend_ch >= NCH) begin
        if (m_cerr < 255) m_cerr++;
      end else if (sz == DEPTH && !pop) begin
        if (m_ovf < 255) m_ovf++;
      end else begin
        push = 1;
      end
    end
    if (pop) begin
      void'(q_smp.pop_front());
      void'(q_ch.pop_front());
    end
    if (push) begin
      q_smp.push_back(pend_smp);
      q_ch.push_back(pend_ch);
    end
    // Byte counting inside one slave-select window.
    if (in_win) begin
      if (spi_done && cnt < FB) begin
        fb[cnt] = spi_dout;
        cnt++;
        if (cnt == FB) done_now = 1;
      end
      if (spi_ss) begin
        if (cnt > 0 && cnt < FB) begin
          if (m_abort < 255) m_abort++;
        end
        in_win = 0;
      end
    end else if (!spi_ss) begin
      in_win = 1;
      cnt    = 0;
    end
    pend = done_now;
    if (done_now) begin
      w = 0;
      for (int i = 0; i < FB; i++) w |= longint'(fb[i]) << (8 * i);
      pend_smp = int'(w & ((64'd1 << SB) - 1));
      pend_ch  = int'((w >> (8 * FB - CB)) & ((64'd1 << CB) - 1));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("m_valid", 32'(m_valid), 32'(q_smp.size() > 0));
        check("fifo_level", 32'(fifo_level), 32'(q_smp.size()));
        check("abort_cnt", 32'(abort_cnt), 32'(m_abort));
        check("chan_err_cnt", 32'(chan_err_cnt), 32'(m_cerr));
        check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
        if (q_smp.size() > 0) begin
          check("m_sample", 32'(m_sample), 32'(q_smp[0]));
          check("m_channel", 32'(m_channel), 32'(q_ch[0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    spi_done = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_done = 1'b1;
    spi_dout = b;
    tick();
    spi_done = 1'b0;
  endtask

  task automatic ss_low();
    spi_ss = 1'b0;
    tick();
  endtask

  task automatic ss_high();
    spi_ss = 1'b1;
    tick();
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1);
    ss_low();
    send_byte(b0);
    send_byte(b1);
    ss_high();
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; spi_ss = 1'b1; spi_done = 1'b0; spi_dout = 8'h00; m_ready = 1'b0;
    repeat (3) tick();
    cmp_en = 1'b1;
    rst = 1'b0;
    check("reset m_valid", 32'(m_valid), 32'd0);
    check("reset level", 32'(fifo_level), 32'd0);
    check("reset sample", 32'(m_sample), 32'd0);
    check("reset counters", 32'({abort_cnt, chan_err_cnt, ovf_cnt}), 32'd0);
    idle(2);

    // Basic frame and its latency.
    ss_low();
    send_byte(8'h5A);
    spi_done = 1'b1; spi_dout = 8'h32;
    tick();
    spi_done = 1'b0;
    check("latency T+1 valid", 32'(m_valid), 32'd0);
    tick();
    check("latency T+2 valid", 32'(m_valid), 32'd1);
    check("frame1 channel", 32'(m_channel), 32'd3);
    check("frame1 sample", 32'(m_sample), 32'h25A);
    ss_high();
    idle(2);
    check("hold while not ready", 32'(m_sample), 32'h25A);
    pop_one();
    check("drained level", 32'(fifo_level), 32'd0);

    // Aborted frame, then a normal one.
    ss_low();
    send_byte(8'h11);
    ss_high();
    check("abort count", 32'(abort_cnt), 32'd1);
    check("abort no push", 32'(fifo_level), 32'd0);
    frame(8'h01, 8'h20);
    idle(2);
    check("after abort level", 32'(fifo_level), 32'd1);
    check("after abort channel", 32'(m_channel), 32'd2);
    check("after abort sample", 32'(m_sample), 32'h001);
    pop_one();

    // Extra byte in the same window is ignored.
    ss_low();
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h99);
    ss_high();
    idle(2);
    check("3byte level", 32'(fifo_level), 32'd1);
    check("3byte channel", 32'(m_channel), 32'd4);
    check("3byte sample", 32'(m_sample), 32'h033);
    check("3byte no abort", 32'(abort_cnt), 32'd1);
    pop_one();

    // Out-of-range channel.
    frame(8'h00, 8'hC0);
    idle(2);
    check("chan err count", 32'(chan_err_cnt), 32'd1);
    check("chan err level", 32'(fifo_level), 32'd0);

    // Overflow, then push and pop in the same cycle on a full FIFO.
    for (int k = 0; k < 10; k++) frame(8'(8'h80 + k), 8'((k % 8) << 4));
    idle(2);
    check("full level", 32'(fifo_level), 32'd8);
    check("ovf count", 32'(ovf_cnt), 32'd2);
    ss_low();
    send_byte(8'hAB);
    spi_done = 1'b1; spi_dout = 8'h50;
    tick();
    spi_done = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("push+pop level", 32'(fifo_level), 32'd8);
    check("push+pop ovf", 32'(ovf_cnt), 32'd2);
    check("push+pop head ch", 32'(m_channel), 32'd1);
    check("push+pop head smp", 32'(m_sample), 32'h081);
    ss_high();
    m_ready = 1'b1;
    idle(12);
    m_ready = 1'b0;

    // Abort counter saturation.
    for (int k = 0; k < 260; k++) begin
      ss_low();
      send_byte(8'($urandom));
      ss_high();
    end
    check("abort saturates", 32'(abort_cnt), 32'hFF);

    // Randomised traffic, two consumer duty cycles.
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(7) == 0) spi_ss = ~spi_ss;
        spi_done = ($urandom_range(2) == 0);
        spi_dout = 8'($urandom);
        m_ready  = (ph == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
        ready    = ($urandom_range(499) != 0);
        rst      = ($urandom_range(999) == 0);
        tick();
      end
    end
    rst = 1'b0; ready = 1'b1; spi_done = 1'b0; m_ready = 1'b0;
    ss_high();
    idle(2);

    // Link drop mid-frame clears everything.
    frame(8'h01, 8'h10);
    frame(8'h02, 8'h10);
    frame(8'h00, 8'hF0);
    ss_low();
    send_byte(8'h22);
    ready = 1'b0;
    tick();
    check("drop m_valid", 32'(m_valid), 32'd0);
    check("drop level", 32'(fifo_level), 32'd0);
    check("drop sample", 32'(m_sample), 32'd0);
    check("drop channel", 32'(m_channel), 32'd0);
    check("drop counters", 32'({abort_cnt, chan_err_cnt, ovf_cnt}), 32'd0);
    spi_ss = 1'b1;
    tick();
    ready = 1'b1;
    tick();

    // Wide-sample build.
    frame(8'hFF, 8'h4F);
    idle(2);
    check("wide valid", 32'(w_valid), 32'd1);
    check("wide channel", 32'(w_channel), 32'd4);
    check("wide sample", 32'(w_sample), 32'hFFF);
    check("narrow sample", 32'(m_sample), 32'h3FF);
    idle(2);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
